// File: rtl/seq_pkg.sv
// Shared types and encodings for the PC sequencer.
// Imported by pc_sequencer and its testbench.
package seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_t;

    localparam logic [1:0] COND_Z  = 2'd0;
    localparam logic [1:0] COND_NZ = 2'd1;
    localparam logic [1:0] COND_P  = 2'd2;
    localparam logic [1:0] COND_C  = 2'd3;

    // Bit positions inside the registered flags vector {sc, pari, zero}
    localparam int F_Z = 0;
    localparam int F_P = 1;
    localparam int F_C = 2;

endpackage

// File: rtl/pc_lut.sv
// Constant branch-target table for absolute jumps.
// Edit build_table() to move jump targets without touching the sequencer.
module pc_lut #(
    parameter int LUT_W = 4,
    parameter int D     = 10
) (
    input  logic [LUT_W-1:0] idx,
    output logic [D-1:0]     target
);

    localparam int ENTRIES = 2 ** LUT_W;

    typedef logic [ENTRIES-1:0][D-1:0] tbl_t;

    function automatic tbl_t build_table();
        tbl_t t;
        for (int i = 0; i < ENTRIES; i++) begin
            t[i] = '0;
        end
        if (ENTRIES > 3) begin
            t[3] = D'(40);
        end
        return t;
    endfunction

    localparam tbl_t TABLE = build_table();

    assign target = TABLE[idx];

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: IDLE/RUN/HALT control, condition flags,
// absolute/relative branching and a saturating run-cycle counter.
module pc_sequencer
    import seq_pkg::*;
#(
    parameter int D     = 10,
    parameter int LUT_W = 4,
    parameter int OFF_W = 6,
    parameter int START = 0,
    parameter int CW    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    output logic             done,
    output logic             running,
    output logic [D-1:0]     prog_ctr,
    input  logic             halt,
    input  logic             absj,
    input  logic             relj,
    input  logic             branch,
    input  logic [1:0]       cond_sel,
    input  logic [LUT_W-1:0] tgt_idx,
    input  logic [OFF_W-1:0] rel_off,
    input  logic             flag_we,
    input  logic             zero_in,
    input  logic             pari_in,
    input  logic             sc_in,
    output logic [2:0]       flags,
    output logic [CW-1:0]    cycle_cnt
);

    state_t       state;
    logic [D-1:0] lut_tgt;
    logic [D-1:0] rel_ext;
    logic         cond;
    logic         taken;

    pc_lut #(
        .LUT_W (LUT_W),
        .D     (D)
    ) u_lut (
        .idx    (tgt_idx),
        .target (lut_tgt)
    );

    assign rel_ext = {{(D - OFF_W){rel_off[OFF_W-1]}}, rel_off};

    // Conditions see the flags as registered before this edge.
    always_comb begin
        cond = 1'b0;
        unique case (cond_sel)
            COND_Z:  cond = flags[F_Z];
            COND_NZ: cond = ~flags[F_Z];
            COND_P:  cond = flags[F_P];
            COND_C:  cond = flags[F_C];
            default: cond = 1'b0;
        endcase
    end

    assign taken = (absj | relj) & (~branch | cond);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            prog_ctr  <= D'(START);
            flags     <= '0;
            cycle_cnt <= '0;
            done      <= 1'b0;
            running   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_HALT: begin
                    if (req) begin
                        state     <= S_RUN;
                        prog_ctr  <= D'(START);
                        flags     <= '0;
                        cycle_cnt <= '0;
                        done      <= 1'b0;
                        running   <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (cycle_cnt != '1) begin
                        cycle_cnt <= cycle_cnt + CW'(1);
                    end
                    if (flag_we) begin
                        flags <= {sc_in, pari_in, zero_in};
                    end
                    if (halt) begin
                        state   <= S_HALT;
                        done    <= 1'b1;
                        running <= 1'b0;
                    end else if (taken && absj) begin
                        prog_ctr <= lut_tgt;
                    end else if (taken) begin
                        prog_ctr <= prog_ctr + rel_ext;
                    end else begin
                        prog_ctr <= prog_ctr + D'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer (default build plus a CW=4 build
// sharing the same stimulus for the counter saturation case).
module tb_pc_sequencer;
    import seq_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       req;
    logic       halt, absj, relj, branch;
    logic [1:0] cond_sel;
    logic [3:0] tgt_idx;
    logic [5:0] rel_off;
    logic       flag_we, zero_in, pari_in, sc_in;

    logic        done, running;
    logic [9:0]  prog_ctr;
    logic [2:0]  flags;
    logic [15:0] cycle_cnt;

    logic        s_done, s_running;
    logic [9:0]  s_prog_ctr;
    logic [2:0]  s_flags;
    logic [3:0]  s_cycle_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .req(req),
        .done(done), .running(running), .prog_ctr(prog_ctr),
        .halt(halt), .absj(absj), .relj(relj), .branch(branch),
        .cond_sel(cond_sel), .tgt_idx(tgt_idx), .rel_off(rel_off),
        .flag_we(flag_we), .zero_in(zero_in), .pari_in(pari_in),
        .sc_in(sc_in), .flags(flags), .cycle_cnt(cycle_cnt)
    );

    pc_sequencer #(.CW(4)) dut_s (
        .clk(clk), .reset(reset), .req(req),
        .done(s_done), .running(s_running), .prog_ctr(s_prog_ctr),
        .halt(halt), .absj(absj), .relj(relj), .branch(branch),
        .cond_sel(cond_sel), .tgt_idx(tgt_idx), .rel_off(rel_off),
        .flag_we(flag_we), .zero_in(zero_in), .pari_in(pari_in),
        .sc_in(sc_in), .flags(s_flags), .cycle_cnt(s_cycle_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_dec();
        halt = 0; absj = 0; relj = 0; branch = 0;
        flag_we = 0; req = 0;
    endtask

    initial begin
        reset = 1; req = 0; halt = 0; absj = 0; relj = 0; branch = 0;
        cond_sel = 0; tgt_idx = 0; rel_off = 0;
        flag_we = 0; zero_in = 0; pari_in = 0; sc_in = 0;
        step(); step();
        reset = 0;
        chk("rst_pc", 32'(prog_ctr), 0);
        chk("rst_flags", 32'(flags), 0);
        chk("rst_cnt", 32'(cycle_cnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_run", 32'(running), 0);
        step();
        chk("idle_hold_run", 32'(running), 0);

        // Start run, count to 5, halt there
        req = 1; step(); req = 0;
        chk("start_run", 32'(running), 1);
        chk("start_pc", 32'(prog_ctr), 0);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("seq_pc%0d", i), 32'(prog_ctr), 32'(i));
        end
        halt = 1; step(); halt = 0;
        chk("halt_done", 32'(done), 1);
        chk("halt_run", 32'(running), 0);
        chk("halt_pc", 32'(prog_ctr), 5);
        chk("halt_cnt", 32'(cycle_cnt), 6);
        step();
        chk("halt_pc_hold", 32'(prog_ctr), 5);
        chk("halt_cnt_hold", 32'(cycle_cnt), 6);

        // Restart from HALT; relative jumps with wrap
        req = 1; step(); req = 0;
        chk("restart_done", 32'(done), 0);
        chk("restart_pc", 32'(prog_ctr), 0);
        chk("restart_cnt", 32'(cycle_cnt), 0);
        relj = 1; rel_off = 6'h3E; step();
        chk("rel_wrap_neg", 32'(prog_ctr), 1022);
        rel_off = 6'd2; step();
        chk("rel_wrap_pos", 32'(prog_ctr), 0);
        rel_off = 6'd7; step();
        chk("rel_to7", 32'(prog_ctr), 7);
        rel_off = 6'h3D; step();
        chk("rel_m3", 32'(prog_ctr), 4);
        relj = 0;

        // Flags and conditional branches
        flag_we = 1; zero_in = 1; pari_in = 0; sc_in = 1; step();
        flag_we = 0;
        chk("flags_latch", 32'(flags), 32'b101);
        chk("flags_pc", 32'(prog_ctr), 5);
        relj = 1; branch = 1; cond_sel = COND_Z; rel_off = 6'd10; step();
        chk("br_z_taken", 32'(prog_ctr), 15);
        cond_sel = COND_NZ; step();
        chk("br_nz_not", 32'(prog_ctr), 16);
        cond_sel = COND_Z; flag_we = 1; zero_in = 0; sc_in = 0; step();
        flag_we = 0;
        chk("br_old_flag", 32'(prog_ctr), 26);
        chk("flags_new", 32'(flags), 0);
        step();
        chk("br_new_flag", 32'(prog_ctr), 27);
        cond_sel = COND_C; step();
        chk("br_c_not", 32'(prog_ctr), 28);

        // req ignored in RUN
        clr_dec(); req = 1; step(); req = 0;
        chk("req_in_run", 32'(prog_ctr), 29);

        // absj beats relj; halt beats absj
        absj = 1; relj = 1; tgt_idx = 4'd3; rel_off = 6'd1; step();
        chk("absj_win", 32'(prog_ctr), 40);
        relj = 0; halt = 1; step(); halt = 0;
        chk("halt_absj_pc", 32'(prog_ctr), 40);
        chk("halt_absj_done", 32'(done), 1);
        flag_we = 1; zero_in = 1; step();
        chk("halt_ign_absj", 32'(prog_ctr), 40);
        chk("halt_ign_flag", 32'(flags), 0);
        clr_dec();

        // Reset mid-run overrides req and decoder inputs
        req = 1; step(); req = 0;
        relj = 1; rel_off = 6'd12; flag_we = 1; zero_in = 1; step();
        chk("mid_pc12", 32'(prog_ctr), 12);
        chk("mid_flags", 32'(flags), 1);
        reset = 1; req = 1; step();
        reset = 0; clr_dec();
        chk("mid_rst_pc", 32'(prog_ctr), 0);
        chk("mid_rst_flags", 32'(flags), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_run", 32'(running), 0);
        chk("mid_rst_cnt", 32'(cycle_cnt), 0);

        // Counter saturation on the CW=4 build
        req = 1; step(); req = 0;
        for (int i = 0; i < 20; i++) step();
        chk("sat_small", 32'(s_cycle_cnt), 15);
        chk("sat_big", 32'(cycle_cnt), 20);
        chk("sat_small_pc", 32'(s_prog_ctr), 20);
        chk("sat_small_run", 32'(s_running), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
